// File: rtl/ro_sample_ctrl_pkg.sv
// Shared types and constants for the ring-oscillator measurement sequencer.
package ro_sample_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_ARM, S_WAIT, S_ACCUM, S_OUT
  } state_e;

  localparam logic [31:0] GO_DONE_MASK = 32'h8000_0000;
  localparam logic        RESET_COND   = 1'b0;

  // Sum of 2^avg_log2 samples of (bus_w-1) bits never overflows this width.
  function automatic int acc_width(input int bus_w, input int avg_log2);
    return bus_w - 1 + avg_log2;
  endfunction

endpackage

// File: rtl/ro_sample_ctrl_if.sv
// Bus-side and counter-side signals of ro_sample_ctrl; slave = sequencer, master = its environment.
interface ro_sample_ctrl_if #(parameter int BUS_WIDTH = 32);
  logic                 start;
  logic [BUS_WIDTH-1:0] window;
  logic [BUS_WIDTH-1:0] go_count;
  logic [BUS_WIDTH-1:0] osc_count;
  logic [BUS_WIDTH-1:0] result;
  logic                 result_valid;
  logic                 result_ready;
  logic                 busy;
  logic                 err_wdog;

  modport slave (
    input  start, window, osc_count, result_ready,
    output go_count, result, result_valid, busy, err_wdog
  );

  modport master (
    output start, window, osc_count, result_ready,
    input  go_count, result, result_valid, busy, err_wdog
  );
endinterface

// File: rtl/ro_bus_sync.sv
// Two-flop synchroniser per bit plus a third register; a word is trusted only when
// stages 2 and 3 agree and its done flag is set, which rejects torn multi-bit captures.
module ro_bus_sync
  import ro_sample_ctrl_pkg::*;
#(
  parameter int           W    = 32,
  parameter logic [W-1:0] MASK = '1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o,
  output logic         stable_o
);
  logic [W-1:0] s1_q, s2_q, s3_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (resetn == RESET_COND) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign q_o      = s2_q;
  assign stable_o = (s2_q == s3_q) && |(s2_q & MASK);
endmodule

// File: rtl/ro_sample_ctrl.sv
// Ring-oscillator measurement sequencer: repeats 2^AVG_LOG2 windowed counts and returns the floor average.
// Optional abort watchdog on WAIT is enabled by defining RO_SAMPLE_WATCHDOG_EN.
module ro_sample_ctrl
  import ro_sample_ctrl_pkg::*;
#(
  parameter int                   BUS_WIDTH     = 32,
  parameter logic [BUS_WIDTH-1:0] GO_DONE_MASK  = BUS_WIDTH'(ro_sample_ctrl_pkg::GO_DONE_MASK),
  parameter int                   AVG_LOG2      = 3,
  parameter int                   SETTLE_CYCLES = 4,
  parameter int                   WDOG_CYCLES   = 1024
) (
  input  logic             clk,
  input  logic             resetn,
  ro_sample_ctrl_if.slave  bus
);
  localparam int ACC_W = acc_width(BUS_WIDTH, AVG_LOG2);
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] N_SAMPLES = CNT_W'(2 ** AVG_LOG2);

  state_e               state_q, state_d;
  logic [SET_W-1:0]     set_q, set_d;
  logic [BUS_WIDTH-1:0] win_q, win_d, go_q, go_d, res_q, res_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]     smp_q, smp_d;
  logic                 err_q, err_d;
  logic [BUS_WIDTH-1:0] s_data;
  logic                 s_stable;
  logic                 unused_done_bit;

  assign unused_done_bit = s_data[BUS_WIDTH-1];

  ro_bus_sync #(.W(BUS_WIDTH), .MASK(GO_DONE_MASK)) u_sync (
    .clk      (clk),
    .resetn   (resetn),
    .d_i      (bus.osc_count),
    .q_o      (s_data),
    .stable_o (s_stable)
  );

`ifdef RO_SAMPLE_WATCHDOG_EN
  logic [BUS_WIDTH:0] wd_q, wd_d;
`else
  localparam int unused_wdog = WDOG_CYCLES;
`endif

  always_comb begin
    state_d = state_q;
    set_d   = set_q;
    win_d   = win_q;
    acc_d   = acc_q;
    smp_d   = smp_q;
    res_d   = res_q;
    err_d   = err_q;
`ifdef RO_SAMPLE_WATCHDOG_EN
    wd_d    = wd_q;
`endif
    case (state_q)
      S_IDLE: if (bus.start && bus.window != '0) begin
        win_d   = bus.window;
        acc_d   = '0;
        smp_d   = '0;
        set_d   = '0;
        err_d   = 1'b0;
        state_d = S_CLEAR;
      end
      S_CLEAR: begin
        if (set_q == SET_W'(SETTLE_CYCLES - 1)) state_d = S_ARM;
        else                                    set_d   = set_q + 1'b1;
      end
      S_ARM: begin
        state_d = S_WAIT;
`ifdef RO_SAMPLE_WATCHDOG_EN
        wd_d    = {1'b0, win_q} + (BUS_WIDTH+1)'(WDOG_CYCLES);
`endif
      end
      S_WAIT: begin
        if (s_stable) begin
          acc_d   = acc_q + ACC_W'(s_data[BUS_WIDTH-2:0]);
          smp_d   = smp_q + 1'b1;
          state_d = S_ACCUM;
        end
`ifdef RO_SAMPLE_WATCHDOG_EN
        // Abort on the cycle the down-counter would reach zero.
        else if (wd_q == (BUS_WIDTH+1)'(1)) begin
          err_d   = 1'b1;
          res_d   = '0;
          state_d = S_OUT;
        end else begin
          wd_d = wd_q - 1'b1;
        end
`endif
      end
      S_ACCUM: begin
        if (smp_q == N_SAMPLES) begin
          res_d   = BUS_WIDTH'(acc_q >> AVG_LOG2);
          state_d = S_OUT;
        end else begin
          set_d   = '0;
          state_d = S_CLEAR;
        end
      end
      S_OUT: if (bus.result_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Registered so the counter stage never sees a decode glitch on the window bus.
    go_d = (state_d == S_ARM || state_d == S_WAIT) ? win_d : '0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (resetn == RESET_COND) begin
      state_q <= S_IDLE;
      set_q   <= '0;
      win_q   <= '0;
      acc_q   <= '0;
      smp_q   <= '0;
      go_q    <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
`ifdef RO_SAMPLE_WATCHDOG_EN
      wd_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      set_q   <= set_d;
      win_q   <= win_d;
      acc_q   <= acc_d;
      smp_q   <= smp_d;
      go_q    <= go_d;
      res_q   <= res_d;
      err_q   <= err_d;
`ifdef RO_SAMPLE_WATCHDOG_EN
      wd_q    <= wd_d;
`endif
    end
  end

  assign bus.go_count     = go_q;
  assign bus.result       = res_q;
  assign bus.result_valid = (state_q == S_OUT);
  assign bus.busy         = (state_q != S_IDLE);
`ifdef RO_SAMPLE_WATCHDOG_EN
  assign bus.err_wdog     = err_q;
`else
  assign bus.err_wdog     = 1'b0;
`endif
endmodule

// File: tb/tb_ro_sample_ctrl.sv
// Scoreboard bench for ro_sample_ctrl: a behavioural counter-stage model feeds osc_count,
// expected averages are queued at stimulus time and checked on every result handshake.
module tb_ro_sample_ctrl;
  localparam int BW = 32, AVG = 3, NS = 8, SETTLE = 4, WDOG = 16;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  ro_sample_ctrl_if #(.BUS_WIDTH(BW)) bus();

  ro_sample_ctrl #(
    .BUS_WIDTH(BW), .GO_DONE_MASK(32'h8000_0000), .AVG_LOG2(AVG),
    .SETTLE_CYCLES(SETTLE), .WDOG_CYCLES(WDOG)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  typedef struct { longint res; bit err; int arms; } exp_t;
  exp_t        exp_q[$];
  logic [30:0] val_q[$];
  bit          gl_q[$];
  bit          no_done = 1'b0;
  int          cur_win = 0;
  int          checks = 0, errors = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, req, req, $time);
    end
  endtask

  // Counter stage model: zero while go_count is 0; after go_count cycles it presents the
  // next queued count with the done flag, optionally preceded by 5 cycles of torn garbage.
  int          m_cnt = 0, m_gl = 0;
  bit          m_done = 1'b0;
  logic [30:0] m_v = '0;
  logic [31:0] g;
  always @(posedge clk) begin
    #1;
    if (bus.go_count == 0) begin
      bus.osc_count = '0; m_cnt = 0; m_gl = 0; m_done = 1'b0;
    end else if (no_done) begin
      m_cnt++;
      bus.osc_count = 32'(m_cnt) & 32'h7fff_ffff;
    end else begin
      if (!m_done) begin
        m_cnt++;
        if (m_cnt >= int'(bus.go_count) && val_q.size() > 0) begin
          m_v = val_q.pop_front();
          m_gl = gl_q.pop_front() ? 5 : 0;
          m_done = 1'b1;
        end
      end
      if (m_done) begin
        if (m_gl > 0) begin
          do g = {1'b1, 31'($urandom)}; while (g == bus.osc_count || g == {1'b1, m_v});
          bus.osc_count = g;
          m_gl--;
        end else bus.osc_count = {1'b1, m_v};
      end
    end
  end

  always @(posedge clk) begin
    #1 bus.result_ready = ($urandom_range(0, 2) != 0);
  end

  // Monitor: window on each arm, result hold while stalled, scoreboard pop on handshake.
  logic [31:0] prev_go = '0, prev_res = '0;
  bit          prev_v = 1'b0;
  int          arms = 0;
  exp_t        e;
  always @(negedge clk) begin
    if (!resetn) begin
      prev_v = 1'b0; prev_go = '0; arms = 0;
    end else begin
      if (bus.go_count != 0 && prev_go == 0) begin
        arms++;
        chk("go_window", bus.go_count, cur_win);
      end
      prev_go = bus.go_count;
      if (bus.result_valid) begin
        if (prev_v) chk("result_hold", bus.result, prev_res);
        if (bus.result_ready) begin
          if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("result", bus.result, e.res);
            chk("err_wdog", bus.err_wdog, e.err);
            chk("arm_count", arms, e.arms);
          end
          arms = 0; prev_v = 1'b0;
        end else begin
          prev_v = 1'b1; prev_res = bus.result;
        end
      end else if (prev_v) begin
        chk("valid_dropped", 0, 1);
        prev_v = 1'b0;
      end
    end
  end

  task automatic pulse(input int win);
    @(posedge clk); #1 bus.start = 1'b1; bus.window = 32'(win);
    @(posedge clk); #1 bus.start = 1'b0;
  endtask

  task automatic run_meas(input int win, input logic [30:0] v[NS], input bit gl[NS]);
    longint s = 0;
    for (int i = 0; i < NS; i++) begin
      val_q.push_back(v[i]); gl_q.push_back(gl[i]); s += longint'(v[i]);
    end
    exp_q.push_back('{res: s >> AVG, err: 1'b0, arms: NS});
    cur_win = win;
    pulse(win);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    @(negedge clk);
    while ((bus.busy || exp_q.size() != 0) && n < budget) begin @(negedge clk); n++; end
    if (n >= budget) chk({name, "_timeout"}, 1, 0);
  endtask

  task automatic wait_go(input int budget);
    int n = 0;
    while (bus.go_count == 0 && n < budget) begin @(negedge clk); n++; end
    if (n >= budget) chk("go_timeout", 1, 0);
  endtask

  logic [30:0] v[NS];
  bit          gl[NS];

  initial begin
    bus.start = 1'b0; bus.window = '0; bus.osc_count = '0; bus.result_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_go", bus.go_count, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_valid", bus.result_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_err", bus.err_wdog, 0);
    resetn = 1'b1;

    // Constant 100-count samples over a 1000-cycle window.
    for (int i = 0; i < NS; i++) begin v[i] = 31'd100; gl[i] = 1'b0; end
    run_meas(1000, v, gl);
    wait_idle(12000, "t_const");

    // Floor: sum 87 / 8 = 10.
    for (int i = 0; i < NS; i++) begin v[i] = (i == 0) ? 31'd10 : 31'd11; gl[i] = 1'b0; end
    run_meas(20, v, gl);
    wait_idle(2000, "t_floor");

    // Torn captures before each settled 200.
    for (int i = 0; i < NS; i++) begin v[i] = 31'd200; gl[i] = 1'b1; end
    run_meas(30, v, gl);
    wait_idle(2000, "t_torn");

    // Zero window is ignored.
    pulse(0);
    @(negedge clk); chk("zero_win_busy", bus.busy, 0);
    @(negedge clk); chk("zero_win_busy2", bus.busy, 0);

    // Second start mid-measurement must not change the window.
    for (int i = 0; i < NS; i++) begin v[i] = 31'($urandom); gl[i] = 1'(i % 2); end
    run_meas(50, v, gl);
    wait_go(200);
    pulse(7);
    chk("busy_mid", bus.busy, 1);
    wait_idle(3000, "t_restart_ignored");

    // Reset during WAIT, then a clean restart.
    for (int i = 0; i < NS; i++) begin v[i] = 31'd77; gl[i] = 1'b0; end
    run_meas(300, v, gl);
    wait_go(200);
    repeat (20) @(negedge clk);
    @(posedge clk); #1 resetn = 1'b0;
    #1;
    chk("rst_mid_go", bus.go_count, 0);
    chk("rst_mid_busy", bus.busy, 0);
    exp_q.delete(); val_q.delete(); gl_q.delete();
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    for (int i = 0; i < NS; i++) begin v[i] = 31'(1000 + 3 * i); gl[i] = 1'b0; end
    run_meas(25, v, gl);
    wait_idle(3000, "t_after_reset");

    // Randomized windows, counts and torn patterns.
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < NS; i++) begin v[i] = 31'($urandom); gl[i] = 1'($urandom_range(0, 1)); end
      run_meas($urandom_range(1, 40), v, gl);
      wait_idle(3000, "t_random");
    end

`ifdef RO_SAMPLE_WATCHDOG_EN
    begin
      int n;
      no_done = 1'b1;
      exp_q.push_back('{res: 0, err: 1'b1, arms: 1});
      cur_win = 100;
      pulse(100);
      n = 0;
      while (!bus.result_valid && n < 500) begin @(negedge clk); n++; end
      chk("wdog_latency_ok", (n <= SETTLE + 1 + 100 + WDOG + 1) ? 1 : 0, 1);
      wait_idle(1000, "t_wdog");
      no_done = 1'b0;
      chk("wdog_sticky", bus.err_wdog, 1);
      for (int i = 0; i < NS; i++) begin v[i] = 31'd5; gl[i] = 1'b0; end
      run_meas(10, v, gl);
      @(negedge clk);
      chk("wdog_clear", bus.err_wdog, 0);
      wait_idle(2000, "t_wdog_after");
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not complete, expected finish before %0t", $time);
    $fatal(1);
  end
endmodule
